i2c_slave: RTL and testbench
============================

# i2c_slave

I2C target (slave) block for the I2C interface library: it decodes START/STOP, matches a 7-bit device address, and ACKs. It takes a sub-address (register pointer) byte and then turns write bytes into single-cycle register-write strobes; for reads it serialises bytes fetched from a user register file. It sits opposite `I2C_master`-style initiators on the same `i2c_sda`/`i2c_scl` bus. It is oversampled by a system clock at least 8x the SCL rate.

## Interface
- `DEV_ADDR`, default 7'b1101000: 7-bit device address the block responds to.
- `clk`  in  1: system clock; must run at least 8x SCL.
- `reset`  in  1: asynchronous, active-low reset; all state clears while low.
- `i2c_scl`  in  1: bus clock; the block never stretches SCL.
- `i2c_sda`  inout  1: open-drain data; the block drives 0 or 1'bZ only.
- `wr_en`  out  1: one-cycle write strobe.
- `wr_addr`  out  8: register address for `wr_en`.
- `wr_data`  out  8: write data for `wr_en`.
- `rd_addr`  out  8: current read pointer; the user returns `rd_data` combinationally or registered within 2 clk.
- `rd_data`  in  8: read byte for `rd_addr`.
- `busy`  out  1: high from an address-matched START to STOP/mismatch.

## Operation
- SCL and SDA each pass through a 2-flop synchroniser plus a history flop. Edges are detected on the synchronised signals.
- START is SDA falling while SCL is high; it is accepted in any state, including repeated START. On START: go to ADDR, bit count = 7, SDA released.
- STOP is SDA rising while SCL is high; it is accepted in any state. On STOP: go to IDLE, release SDA, `busy` = 0. A partial byte is discarded and produces no `wr_en`.
- Bits are sampled on synchronised SCL rising edges, MSB first. SDA is changed only on synchronised SCL falling edges.
- States and transitions:
  - IDLE: waits for START.
  - ADDR: receives 7 address bits plus R/W. A mismatch goes to IGNORE, which never drives SDA and leaves only on START or STOP. A match goes to ADDR_ACK.
  - ADDR_ACK: drives SDA low from the fall after bit 8 to the next fall. With W=0, next is SUB. With R=1, load the shift register from `rd_data` and go to RDATA.
  - SUB: receives 8 bits into the pointer, then SUB_ACK, then WDATA.
  - WDATA: receives 8 bits, then WDATA_ACK. Pulse `wr_en` with `wr_addr` = pointer; pointer += 1. Stay in the WDATA/WDATA_ACK loop until STOP or START.
  - RDATA: drives SDA = 0 for a 0 bit and Z for a 1 bit for 8 bits, then releases SDA. MACK samples the master's bit on SCL rise.
    - ACK (0): pointer += 1, reload from `rd_data`, RDATA.
    - NACK (1): IGNORE.
- The pointer is an 8-bit modulo counter: 0xFF+1 wraps to 0x00. The pointer persists across repeated START, so combined write-sub/read transfers work. `rd_addr` = pointer.

## Timing
- Reset values: SDA released (Z), `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `rd_addr` = 0, `busy` = 0, state IDLE, pointer 0.
- Synchroniser plus edge-detect latency is 3 clk. SCL high and low phases must each be at least 4 clk.
- `wr_en` is high for exactly 1 clk, in the cycle the 8th data bit's SCL rise is detected. `wr_addr`/`wr_data` are valid that cycle and hold until the next write.
- The ACK low drive begins within 1 clk of the detected SCL fall after bit 8 and is released within 1 clk of the following detected fall.
- `rd_data` is sampled 2 clk after `rd_addr` changes, which is before the first SCL fall of the byte.
- Reset asserted mid-transfer releases SDA immediately (asynchronous), not on the next edge.

## Structure
- Package `i2c_pkg`: state enum, `I2C_ACK` = 1'b0, `I2C_NACK` = 1'b1, `I2C_ADDR_W` = 7, `I2C_BYTE_W` = 8.
- Sub-module `i2c_sync_edge`: 2-flop synchroniser plus rise/fall pulse outputs, instantiated once for SCL and once for SDA.
- The top level holds the FSM, bit counter, shift register, pointer and SDA open-drain drive.

## Test plan
- **Single write.** START, 0xD0 (0x68 W), 0x20, 0x0F, STOP -> ACK on all 3 bytes; exactly one `wr_en` with `wr_addr` = 0x20, `wr_data` = 0x0F; `busy` high until STOP.
- **Address mismatch.** START, 0xD2 (0x69 W), 0x20, 0x0F, STOP -> SDA never driven low, no `wr_en`, `busy` stays 0.
- **Burst with wrap.** Sub 0xFE, data 0x11/0x22/0x33 -> `wr_en` at addresses 0xFE, 0xFF, 0x00 with matching data.
- **Combined read.** Write sub 0x10, repeated START, 0xD1, model returns 0xA5@0x10 and 0x3C@0x11; master ACKs then NACKs -> SDA carries 0xA5 then 0x3C, then is released; STOP returns to IDLE.
- **Abort.** STOP after 4 bits of a data byte -> no `wr_en`, IDLE. Reset low during SUB bit 3 -> SDA released that cycle, all outputs at reset values; the next single-write transaction succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
// I2C target shared types and constants.
// State encoding plus bus-level ACK polarity and field widths.
package i2c_pkg;

  localparam logic I2C_ACK    = 1'b0;
  localparam logic I2C_NACK   = 1'b1;
  localparam int   I2C_ADDR_W = 7;
  localparam int   I2C_BYTE_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_MACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser with a history flop.
// Gives the synchronised level plus one-cycle rise/fall pulses.
module i2c_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;

  // Idle bus lines sit high, so reset to 1 to avoid a bogus edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sh <= 3'b111;
    else        sh <= {sh[1:0], din};
  end

  assign level = sh[1];
  assign rise  = sh[1] & ~sh[2];
  assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, register pointer, write strobes
// and serialised reads from a user register file.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'b1101000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2c_scl,
  inout  wire                   i2c_sda,
  output logic                  wr_en,
  output logic [I2C_BYTE_W-1:0] wr_addr,
  output logic [I2C_BYTE_W-1:0] wr_data,
  output logic [I2C_BYTE_W-1:0] rd_addr,
  input  logic [I2C_BYTE_W-1:0] rd_data,
  output logic                  busy
);

  logic scl_lv, scl_rise, scl_fall;
  logic sda_lv, sda_rise, sda_fall;
  logic start, stop;

  i2c_sync_edge u_scl (
    .clk   (clk),
    .reset (reset),
    .din   (i2c_scl),
    .level (scl_lv),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk   (clk),
    .reset (reset),
    .din   (i2c_sda),
    .level (sda_lv),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start = sda_fall & scl_lv;
  assign stop  = sda_rise & scl_lv;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_low_q, sda_low_d;
  logic       ack_on_q, ack_on_d;
  logic       busy_q, busy_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [1:0] ld_q;
  logic       ld_go;
  logic [7:0] rx_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd7;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_low_q <= 1'b0;
      ack_on_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ld_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_low_q <= sda_low_d;
      ack_on_q  <= ack_on_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ld_q      <= {ld_q[0], ld_go};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_low_d = sda_low_q;
    ack_on_d  = ack_on_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ld_go     = 1'b0;
    rx_byte   = {shift_q[6:0], sda_lv};

    if (start) begin
      state_d   = ST_ADDR;
      cnt_d     = 3'd7;
      sda_low_d = 1'b0;
      ack_on_d  = 1'b0;
    end else if (stop) begin
      state_d   = ST_IDLE;
      sda_low_d = 1'b0;
      ack_on_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_SUB, ST_WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (cnt_q != 3'd0) begin
              cnt_d = cnt_q - 3'd1;
            end else begin
              unique case (1'b1)
                state_q == ST_ADDR: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_d = ST_ADDR_ACK;
                    busy_d  = 1'b1;
                  end else begin
                    state_d = ST_IGNORE;
                    busy_d  = 1'b0;
                  end
                end
                state_q == ST_SUB: begin
                  ptr_d   = rx_byte;
                  state_d = ST_SUB_ACK;
                end
                default: begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = rx_byte;
                  ptr_d     = ptr_q + 8'd1;
                  state_d   = ST_WDATA_ACK;
                end
              endcase
            end
          end
        end
        ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
          // First fall starts the ACK low, second fall ends it.
          if (scl_fall) begin
            if (!ack_on_q) begin
              ack_on_d  = 1'b1;
              sda_low_d = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              sda_low_d = 1'b0;
              cnt_d     = 3'd7;
              if (state_q != ST_ADDR_ACK) begin
                state_d = ST_WDATA;
              end else if (shift_q[0]) begin
                state_d   = ST_RDATA;
                shift_d   = rd_data;
                sda_low_d = ~rd_data[7];
              end else begin
                state_d = ST_SUB;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_low_d = 1'b0;
              state_d   = ST_MACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_low_d = ~shift_q[6];
              cnt_d     = cnt_q - 3'd1;
            end
          end
        end
        ST_MACK: begin
          // Next byte fetched two clocks after the pointer moves.
          if (ld_q[1]) shift_d = rd_data;
          if (scl_rise) begin
            if (sda_lv == I2C_NACK) begin
              state_d = ST_IGNORE;
            end else begin
              ptr_d    = ptr_q + 8'd1;
              ld_go    = 1'b1;
              ack_on_d = 1'b1;
            end
          end else if (scl_fall && ack_on_q) begin
            ack_on_d  = 1'b0;
            state_d   = ST_RDATA;
            cnt_d     = 3'd7;
            sda_low_d = ~shift_q[7];
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c_sda = sda_low_q ? I2C_ACK : 1'bz;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = ptr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master drives the bus
// and a small register-file model answers reads.
module tb_i2c_slave;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic scl_r = 1'b1;
  logic sda_r = 1'b1;
  wire  sda;

  pullup (sda);
  assign sda = sda_r ? 1'bz : 1'b0;

  logic       wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0] mem [256];

  assign rd_data = mem[rd_addr];

  int errors = 0;
  int checks = 0;
  int low_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] wa_log [$];
  logic [7:0] wd_log [$];

  always #5 clk = ~clk;

  i2c_slave #(.DEV_ADDR(7'h68)) dut (
    .clk     (clk),
    .reset   (reset),
    .i2c_scl (scl_r),
    .i2c_sda (sda),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      wa_log.push_back(wr_addr);
      wd_log.push_back(wr_data);
    end
    if (sda_r && sda === 1'b0) low_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic q;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start;
    sda_r = 1'b1; q();
    scl_r = 1'b1; q();
    sda_r = 1'b0; q();
    scl_r = 1'b0; q();
  endtask

  task automatic i2c_stop;
    sda_r = 1'b0; q();
    scl_r = 1'b1; q();
    sda_r = 1'b1; q();
  endtask

  task automatic write_bit(input logic b);
    sda_r = b; q();
    scl_r = 1'b1; q(); q();
    scl_r = 1'b0; q();
  endtask

  task automatic read_bit(output logic v);
    sda_r = 1'b1; q();
    scl_r = 1'b1; q();
    v = sda; q();
    scl_r = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      d[i] = v;
    end
    write_bit(mack);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sda !== 1'b1) begin
      errors++; $display("FAIL reset_sda got=%b exp=1", sda);
    end
    checks++;
    if (wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en);
    end
    checks++;
    if (wr_addr !== 8'h00 || wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_wr got=%h/%h exp=00/00", wr_addr, wr_data);
    end
    checks++;
    if (rd_addr !== 8'h00) begin
      errors++; $display("FAIL reset_rd_addr got=%h exp=00", rd_addr);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    reset = 1'b1;
    q();
  endtask

  task automatic test_single_write;
    logic a0, a1, a2;
    int n0;
    n0 = wa_log.size();
    i2c_start();
    write_byte(8'hD0, a0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL sw_busy got=%b exp=1", busy);
    end
    write_byte(8'h20, a1);
    write_byte(8'h0F, a2);
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      errors++; $display("FAIL sw_acks got=%b exp=000", {a0, a1, a2});
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL sw_busy_pre_stop got=%b exp=1", busy);
    end
    i2c_stop();
    checks++;
    if (wa_log.size() - n0 != 1) begin
      errors++;
      $display("FAIL sw_count got=%0d exp=1", wa_log.size() - n0);
    end else begin
      checks++;
      if (wa_log[n0] !== 8'h20 || wd_log[n0] !== 8'h0F) begin
        errors++;
        $display("FAIL sw_data got=%h/%h exp=20/0F",
                 wa_log[n0], wd_log[n0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL sw_busy_post got=%b exp=0", busy);
    end
    checks++;
    if (rd_addr !== 8'h21) begin
      errors++; $display("FAIL sw_ptr got=%h exp=21", rd_addr);
    end
  endtask

  task automatic test_mismatch;
    logic a0, a1, a2;
    int n0, l0, b0;
    n0 = wa_log.size();
    l0 = low_cnt;
    b0 = busy_cnt;
    i2c_start();
    write_byte(8'hD2, a0);
    write_byte(8'h20, a1);
    write_byte(8'h0F, a2);
    i2c_stop();
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin
      errors++; $display("FAIL mm_acks got=%b exp=111", {a0, a1, a2});
    end
    checks++;
    if (low_cnt != l0) begin
      errors++; $display("FAIL mm_sda_low got=%0d exp=0", low_cnt - l0);
    end
    checks++;
    if (wa_log.size() != n0) begin
      errors++;
      $display("FAIL mm_wr got=%0d exp=0", wa_log.size() - n0);
    end
    checks++;
    if (busy_cnt != b0) begin
      errors++; $display("FAIL mm_busy got=%0d exp=0", busy_cnt - b0);
    end
  endtask

  task automatic test_burst_wrap;
    logic [7:0] ea [3];
    logic [7:0] ed [3];
    logic a;
    int n0;
    ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
    ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h33;
    n0 = wa_log.size();
    i2c_start();
    write_byte(8'hD0, a);
    write_byte(8'hFE, a);
    for (int i = 0; i < 3; i++) write_byte(ed[i], a);
    i2c_stop();
    checks++;
    if (wa_log.size() - n0 != 3) begin
      errors++;
      $display("FAIL bw_count got=%0d exp=3", wa_log.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa_log[n0+i] !== ea[i] || wd_log[n0+i] !== ed[i]) begin
          errors++;
          $display("FAIL bw_%0d got=%h/%h exp=%h/%h", i,
                   wa_log[n0+i], wd_log[n0+i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_combined_read;
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(8'h10, a1);
    i2c_start();
    write_byte(8'hD1, a2);
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      errors++; $display("FAIL cr_acks got=%b exp=000", {a0, a1, a2});
    end
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    checks++;
    if (d0 !== 8'hA5) begin
      errors++; $display("FAIL cr_byte0 got=%h exp=A5", d0);
    end
    checks++;
    if (d1 !== 8'h3C) begin
      errors++; $display("FAIL cr_byte1 got=%h exp=3C", d1);
    end
    checks++;
    if (sda !== 1'b1) begin
      errors++; $display("FAIL cr_release got=%b exp=1", sda);
    end
    checks++;
    if (rd_addr !== 8'h11) begin
      errors++; $display("FAIL cr_ptr got=%h exp=11", rd_addr);
    end
    i2c_stop();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cr_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_abort;
    logic a;
    int n0;
    n0 = wa_log.size();
    i2c_start();
    write_byte(8'hD0, a);
    write_byte(8'h40, a);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b1);
    i2c_stop();
    checks++;
    if (wa_log.size() != n0) begin
      errors++;
      $display("FAIL ab_wr got=%0d exp=0", wa_log.size() - n0);
    end
    checks++;
    if (busy !== 1'b0 || rd_addr !== 8'h40) begin
      errors++;
      $display("FAIL ab_idle got=%b/%h exp=0/40", busy, rd_addr);
    end
  endtask

  task automatic test_reset_mid;
    logic a;
    int n0;
    i2c_start();
    write_byte(8'hD0, a);
    write_bit(1'b0);
    write_bit(1'b1);
    sda_r = 1'b0; q();
    scl_r = 1'b1; q();
    sda_r = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (sda !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rm_sub got=%b/%b/%b exp=1/0/0", sda, wr_en, busy);
    end
    checks++;
    if (wr_addr !== 8'h00 || wr_data !== 8'h00 || rd_addr !== 8'h00) begin
      errors++;
      $display("FAIL rm_regs got=%h/%h/%h exp=00/00/00",
               wr_addr, wr_data, rd_addr);
    end
    scl_r = 1'b0;
    q();
    reset = 1'b1;
    q();
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(8'hD0 >> i);
    sda_r = 1'b1;
    checks++;
    if (sda !== 1'b0) begin
      errors++; $display("FAIL rm_ack_drive got=%b exp=0", sda);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (sda !== 1'b1) begin
      errors++; $display("FAIL rm_ack_release got=%b exp=1", sda);
    end
    q();
    reset = 1'b1;
    q();
    n0 = wa_log.size();
    i2c_start();
    write_byte(8'hD0, a);
    write_byte(8'h05, a);
    write_byte(8'h99, a);
    i2c_stop();
    checks++;
    if (wa_log.size() - n0 != 1) begin
      errors++;
      $display("FAIL rm_after got=%0d exp=1", wa_log.size() - n0);
    end else begin
      checks++;
      if (wa_log[n0] !== 8'h05 || wd_log[n0] !== 8'h99) begin
        errors++;
        $display("FAIL rm_after_data got=%h/%h exp=05/99",
                 wa_log[n0], wd_log[n0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h3C;
    test_reset();
    test_single_write();
    test_mismatch();
    test_burst_wrap();
    test_combined_read();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
